// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer and press/release pulse
// generator for the active-low push buttons feeding the clock core.
// Optional feature macro: AUTO_REPEAT_EN builds the per-key auto-repeat FSM
// and hold counter; without it key_repeat is tied low.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

`ifdef AUTO_REPEAT_EN
  localparam int                HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int                HOLD_W      = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO   = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2
  } rep_state_e;
`endif

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    // Sync flops keep the raw (active-low) polarity so their reset value of 1
    // means "released" and a key held through reset is seen as a new press.
    logic            sync1_n_q, sync1_n_d;
    logic            sync2_n_q, sync2_n_d;
    logic            pressed_s;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    // Next values of the two-stage synchroniser.
    always_comb begin
      sync1_n_d = key_n_raw[i];
      sync2_n_d = sync1_n_q;
    end

    // Synchroniser registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_n_q <= 1'b1;
        sync2_n_q <= 1'b1;
      end else begin
        sync1_n_q <= sync1_n_d;
        sync2_n_q <= sync2_n_d;
      end
    end

    assign pressed_s = ~sync2_n_q;

    // Debounce: count consecutive cycles the synced value disagrees with the
    // clean level; flip the level and emit an edge pulse on the terminal count.
    always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (pressed_s == level_q) begin
        cnt_d = DB_ZERO;
      end else if (cnt_q == DB_LAST) begin
        cnt_d     = DB_ZERO;
        level_d   = pressed_s;
        press_d   = pressed_s;
        release_d = ~pressed_s;
      end else begin
        cnt_d = cnt_q + DB_ONE;
      end
    end

    // Debounce counter, clean level and press/release pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= DB_ZERO;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;

`ifdef AUTO_REPEAT_EN
    rep_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              repeat_q, repeat_d;

    // Repeat FSM: a level fall always wins and suppresses any pulse that
    // cycle; otherwise the hold counter runs to the delay, then the period.
    always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      repeat_d = 1'b0;
      if (release_d) begin
        state_d = RELEASED;
        hold_d  = HOLD_ZERO;
      end else begin
        case (state_q)
          RELEASED: begin
            hold_d = HOLD_ZERO;
            if (press_d) begin
              state_d = HELD;
            end else begin
              state_d = RELEASED;
            end
          end
          HELD: begin
            if (hold_q == DELAY_LAST) begin
              state_d  = REPEAT;
              hold_d   = HOLD_ZERO;
              repeat_d = 1'b1;
            end else begin
              hold_d = hold_q + HOLD_ONE;
            end
          end
          REPEAT: begin
            if (hold_q == PERIOD_LAST) begin
              hold_d   = HOLD_ZERO;
              repeat_d = 1'b1;
            end else begin
              hold_d = hold_q + HOLD_ONE;
            end
          end
          default: begin
            state_d = RELEASED;
            hold_d  = HOLD_ZERO;
          end
        endcase
      end
    end

    // Repeat FSM state, hold counter and repeat pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= RELEASED;
        hold_q   <= HOLD_ZERO;
        repeat_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        hold_q   <= hold_d;
        repeat_q <= repeat_d;
      end
    end

    assign key_repeat[i] = repeat_q;
`else
    assign key_repeat[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5). Honours AUTO_REPEAT_EN for the repeat expectations.
module tb_key_conditioner;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

`ifdef AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n_raw = 2'b11;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  always #5 clk = ~clk;

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_n_raw(key_n_raw),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: history of pressed samples, one per clock edge.
  logic [NK-1:0] hist[$];
  logic [NK-1:0] m_level, m_press, m_release, m_repeat;
  int            edge_no;
  int            rise_edge[NK];

  task automatic model_reset();
    hist.delete();
    hist.push_back(2'b00);
    hist.push_back(2'b00);
    m_level = 2'b00; m_press = 2'b00; m_release = 2'b00; m_repeat = 2'b00;
    edge_no = 0;
    for (int k = 0; k < NK; k++) rise_edge[k] = 0;
  endtask

  // Level flips when the last DB samples reaching the debouncer (two edges
  // of synchroniser delay) all disagree with it.
  task automatic model_edge(input logic [NK-1:0] raw);
    logic [NK-1:0] old;
    bit            all_diff;
    int            age;
    edge_no++;
    hist.push_back(~raw);
    old = m_level;
    m_press = 2'b00; m_release = 2'b00; m_repeat = 2'b00;
    for (int k = 0; k < NK; k++) begin
      if (edge_no >= DB) begin
        all_diff = 1'b1;
        for (int j = edge_no - DB; j <= edge_no - 1; j++)
          if (hist[j][k] == old[k]) all_diff = 1'b0;
        if (all_diff) m_level[k] = ~old[k];
      end
      if (m_level[k] && !old[k]) begin
        m_press[k] = 1'b1;
        rise_edge[k] = edge_no;
      end
      if (!m_level[k] && old[k]) m_release[k] = 1'b1;
      if (REP_ON && m_level[k] && old[k]) begin
        age = edge_no - rise_edge[k];
        if (age >= RD && ((age - RD) % RP) == 0) m_repeat[k] = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string name);
    checks++;
    if ({key_level, key_press, key_release, key_repeat} !==
        {m_level, m_press, m_release, m_repeat}) begin
      failures++;
      $display("FAIL %s edge=%0d got lvl=%b prs=%b rel=%b rep=%b expected lvl=%b prs=%b rel=%b rep=%b",
               name, edge_no, key_level, key_press, key_release, key_repeat,
               m_level, m_press, m_release, m_repeat);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [NK-1:0] raw, input string name);
    key_n_raw = raw;
    @(posedge clk);
    #1;
    model_edge(raw);
    check_model(name);
  endtask

  // Asserts reset mid-cycle, checks outputs clear immediately, releases it.
  task automatic do_reset(input logic [NK-1:0] raw);
    key_n_raw = raw;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("reset_outputs_zero",
              int'({key_level, key_press, key_release, key_repeat}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [NK-1:0] raw;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
  } vec_t;

  vec_t vecs[15];
  int   press_at, rel_at, n_press, n_rel, n_any, r_edge;
  int   rep_offs[$];
  int   exp_offs[$];
  logic [NK-1:0] rnd_raw;

  initial begin
    // Keys held through reset: both pressed from edge 1, both seen at edge 6,
    // then key 1 released at edge 9 and seen released at edge 14.
    for (int i = 0; i < 15; i++) begin
      vecs[i].raw = (i < 8) ? 2'b00 : 2'b10;
      vecs[i].lvl = (i < 5) ? 2'b00 : ((i < 13) ? 2'b11 : 2'b01);
      vecs[i].prs = (i == 5) ? 2'b11 : 2'b00;
      vecs[i].rel = (i == 13) ? 2'b10 : 2'b00;
    end

    model_reset();
    do_reset(2'b00);
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].raw, "table_model");
      checks++;
      if ({key_level, key_press, key_release} !== {vecs[i].lvl, vecs[i].prs, vecs[i].rel}) begin
        failures++;
        $display("FAIL table edge=%0d got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=%b",
                 i + 1, key_level, key_press, key_release, vecs[i].lvl, vecs[i].prs, vecs[i].rel);
      end
    end

    // Glitch shorter than the debounce window: nothing happens.
    do_reset(2'b11);
    n_any = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, "glitch");
      if ({key_level, key_press, key_release} != 6'd0) n_any++;
    end
    for (int i = 0; i < 10; i++) begin
      step(2'b11, "glitch");
      if ({key_level, key_press, key_release} != 6'd0) n_any++;
    end
    check_val("glitch_no_output", n_any, 0);

    // Clean press for 20 cycles, then release.
    do_reset(2'b11);
    press_at = -1; rel_at = -1;
    for (int i = 1; i <= 20; i++) begin
      step(2'b10, "clean_press");
      if (key_press[0] && press_at < 0) press_at = i;
    end
    for (int i = 1; i <= 10; i++) begin
      step(2'b11, "clean_release");
      if (key_release[0] && rel_at < 0) rel_at = i;
    end
    check_val("clean_press_edge", press_at, 6);
    check_val("clean_release_edge", rel_at, 6);

    // Bounce on key 1: toggling for 8 cycles, then held pressed.
    do_reset(2'b11);
    n_press = 0; n_rel = 0;
    for (int i = 0; i < 23; i++) begin
      step((i < 8) ? ((i % 2 == 0) ? 2'b01 : 2'b11) : 2'b01, "bounce");
      if (key_press[1]) n_press++;
      if (key_release[1]) n_rel++;
    end
    check_val("bounce_one_press", n_press, 1);
    check_val("bounce_no_release", n_rel, 0);

    // Auto-repeat on key 0: held 30 cycles past the level rise.
    do_reset(2'b11);
    r_edge = -1;
    for (int i = 0; i < 20 && r_edge < 0; i++) begin
      step(2'b10, "repeat_press");
      if (key_press[0]) r_edge = edge_no;
    end
    if (r_edge < 0) begin
      check_val("repeat_press_timeout", 0, 1);
      r_edge = edge_no;
    end
    rep_offs.delete();
    for (int i = 0; i < 60; i++) begin
      step((edge_no + 1 - r_edge < 26) ? 2'b10 : 2'b11, "repeat_hold");
      if (key_repeat[0]) rep_offs.push_back(edge_no - r_edge);
      if (key_repeat[0] && key_press[0]) check_val("repeat_with_press", 1, 0);
    end
    exp_offs.delete();
    if (REP_ON) begin
      for (int o = RD; o <= 30; o += RP) exp_offs.push_back(o);
    end
    check_val("repeat_count", rep_offs.size(), exp_offs.size());
    for (int i = 0; i < rep_offs.size() && i < exp_offs.size(); i++)
      check_val("repeat_offset", rep_offs[i], exp_offs[i]);

    // Both keys pressed on the same edge, then reset asserted mid-hold.
    do_reset(2'b11);
    press_at = -1;
    for (int i = 1; i <= 20 && press_at < 0; i++) begin
      step(2'b00, "both_press");
      if (key_press != 2'b00) begin
        press_at = i;
        check_val("both_press_same_cycle", int'(key_press), 3);
      end
    end
    check_val("both_press_edge", press_at, 6);
    for (int i = 0; i < 5; i++) step(2'b00, "both_hold");
    do_reset(2'b00);
    press_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step(2'b00, "after_reset");
      if (key_press == 2'b11 && press_at < 0) press_at = i;
    end
    check_val("press_after_reset_edge", press_at, 6);

    // Randomised traffic against the model, mixing bouncy and steady phases.
    for (int round = 0; round < 3; round++) begin
      do_reset(2'($urandom_range(0, 3)));
      rnd_raw = key_n_raw;
      for (int i = 0; i < 1500; i++) begin
        for (int k = 0; k < NK; k++) begin
          if ($urandom_range(0, 99) < (((i / 100) % 2 == 0) ? 35 : 3))
            rnd_raw[k] = ~rnd_raw[k];
        end
        step(rnd_raw, "random");
        if (key_press & key_release) check_val("press_release_overlap", 1, 0);
        if (key_press & key_repeat) check_val("press_repeat_overlap", 1, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
